// File: rtl/ram_pkg.sv
// Shared types and helpers for the pipelined simple-dual-port RAM.
package ram_pkg;

    typedef enum logic [1:0] {
        RAM_NO_CHANGE,
        RAM_WRITE_FIRST,
        RAM_READ_FIRST
    } ram_mode_e;

    typedef enum logic [1:0] {
        INIT_IDLE,
        INIT_CLEAR,
        INIT_READY
    } ram_init_state_e;

    localparam int RD_LATENCY_MAX = 3;

    function automatic int rd_lat_clamp(int lat);
        if (lat < 1) return 1;
        if (lat > RD_LATENCY_MAX) return RD_LATENCY_MAX;
        return lat;
    endfunction

    function automatic int idx_width(int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_sdp_pipe_if.sv
// Write/read port bundle of ram_sdp_pipe.
interface ram_sdp_pipe_if
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  wen;
    logic [NB-1:0]         wbe;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] din;
    logic                  ren;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_vld;
    logic                  rd_coll;
    logic                  init_busy;

    modport master (
        output wen, wbe, addra, din,
        output ren, addrb,
        input  dout, dout_vld, rd_coll, init_busy
    );

    modport slave (
        input  wen, wbe, addra, din,
        input  ren, addrb,
        output dout, dout_vld, rd_coll, init_busy
    );

endinterface

// File: rtl/ram_rd_pipe.sv
// Read pipeline: stage 1 takes the array read, later stages are output registers.
module ram_rd_pipe
    import ram_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic                  in_coll,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_vld,
    output logic                  out_coll,
    output logic [DATA_WIDTH-1:0] out_data
);
    localparam int N = rd_lat_clamp(RD_LATENCY);

    logic [N-1:0]          vld;
    logic [N-1:0]          coll;
    logic [DATA_WIDTH-1:0] data [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= '0;
            coll <= '0;
        end else begin
            vld[0]  <= in_vld;
            coll[0] <= in_coll;
            for (int i = 1; i < N; i++) begin
                vld[i]  <= vld[i-1];
                coll[i] <= coll[i-1];
            end
        end
    end

    // Data only moves with its valid bit so dout holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                data[i] <= '0;
            end
        end else begin
            if (in_vld) begin
                data[0] <= in_data;
            end
            for (int i = 1; i < N; i++) begin
                if (vld[i-1]) begin
                    data[i] <= data[i-1];
                end
            end
        end
    end

    assign out_vld  = vld[N-1];
    assign out_coll = coll[N-1];
    assign out_data = data[N-1];

endmodule

// File: rtl/ram_sdp_pipe.sv
// Simple-dual-port RAM: byte enables, 1..3 cycle read pipeline, collision flag.
// Define RAM_INIT_CLEAR_EN to add the post-reset sequential clear engine.
module ram_sdp_pipe
    import ram_pkg::*;
#(
    parameter int        DATA_WIDTH    = 32,
    parameter int        BYTE_WIDTH    = 8,
    parameter int        ADDR_WIDTH    = 10,
    parameter int        DATA_DEPTH    = 1024,
    parameter int        RD_LATENCY    = 1,
    parameter string     RAM_STYLE_VAL = "block",
    parameter ram_mode_e MODE          = RAM_NO_CHANGE
) (
    input logic           clk,
    input logic           rst,
    ram_sdp_pipe_if.slave bus
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    localparam int IW = idx_width(DATA_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DATA_DEPTH - 1);

`ifdef RAM_INIT_CLEAR_EN
    (* ram_style = RAM_STYLE_VAL *)
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
`else
    (* ram_style = RAM_STYLE_VAL *)
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH] = '{default: '0};
`endif

    logic                  busy;
    logic                  clr_we;
    logic [IW-1:0]         clr_idx;
    logic [IW-1:0]         wa;
    logic [IW-1:0]         ra;
    logic                  wa_ok;
    logic                  ra_ok;
    logic                  wr_en;
    logic                  rd_en;
    logic                  coll;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_vld;

`ifdef RAM_INIT_CLEAR_EN
    ram_init_state_e state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT_CLEAR;
            clr_idx <= '0;
        end else begin
            unique case (state)
                INIT_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST) begin
                        state <= INIT_READY;
                    end
                end
                INIT_READY: state <= INIT_READY;
                default:    state <= INIT_CLEAR;
            endcase
        end
    end

    assign busy   = (state == INIT_CLEAR);
    assign clr_we = busy && !rst;
`else
    assign busy    = 1'b0;
    assign clr_we  = 1'b0;
    assign clr_idx = LAST;
`endif

    assign wa    = bus.addra[IW-1:0];
    assign ra    = bus.addrb[IW-1:0];
    assign wa_ok = ({1'b0, bus.addra} < DEPTH);
    assign ra_ok = ({1'b0, bus.addrb} < DEPTH);
    assign wr_en = bus.wen && !busy && wa_ok;
    assign rd_en = bus.ren && !busy;

    assign coll = bus.wen && bus.ren && !busy
                  && (bus.addra == bus.addrb)
                  && (|bus.wbe);

    assign old_word = ra_ok ? mem[ra] : '0;

    always_comb begin
        merged = old_word;
        for (int i = 0; i < NB; i++) begin
            if (bus.wbe[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] =
                    bus.din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // A colliding read either vanishes or sees the merged word, by mode.
    always_comb begin
        s1_vld  = rd_en;
        s1_data = old_word;
        unique case (1'b1)
            coll && (MODE == RAM_NO_CHANGE):   s1_vld  = 1'b0;
            coll && (MODE == RAM_WRITE_FIRST): s1_data = ra_ok ? merged : '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wbe[i]) begin
                    mem[wa][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        bus.din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    ram_rd_pipe #(
        .RD_LATENCY (RD_LATENCY),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (s1_vld),
        .in_coll  (coll),
        .in_data  (s1_data),
        .out_vld  (bus.dout_vld),
        .out_coll (bus.rd_coll),
        .out_data (bus.dout)
    );

    assign bus.init_busy = busy;

endmodule

// File: tb/tb_ram_sdp_pipe.sv
// Directed bench: three ram_sdp_pipe instances (lat 1/3/2, one per collision mode).
module tb_ram_sdp_pipe;
    import ram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [3:0]  wbe;
    logic [9:0]  addra;
    logic [31:0] din;
    logic        ren;
    logic [9:0]  addrb;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_sdp_pipe_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10)) ifa ();
    ram_sdp_pipe_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10)) ifb ();
    ram_sdp_pipe_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10)) ifc ();

    assign ifa.wen = wen;   assign ifb.wen = wen;   assign ifc.wen = wen;
    assign ifa.wbe = wbe;   assign ifb.wbe = wbe;   assign ifc.wbe = wbe;
    assign ifa.addra = addra; assign ifb.addra = addra; assign ifc.addra = addra;
    assign ifa.din = din;   assign ifb.din = din;   assign ifc.din = din;
    assign ifa.ren = ren;   assign ifb.ren = ren;   assign ifc.ren = ren;
    assign ifa.addrb = addrb; assign ifb.addrb = addrb; assign ifc.addrb = addrb;

    ram_sdp_pipe #(
        .DATA_DEPTH(1024), .RD_LATENCY(1), .MODE(RAM_READ_FIRST)
    ) u_a (.clk(clk), .rst(rst), .bus(ifa));

    ram_sdp_pipe #(
        .DATA_DEPTH(1000), .RD_LATENCY(3), .MODE(RAM_WRITE_FIRST)
    ) u_b (.clk(clk), .rst(rst), .bus(ifb));

    ram_sdp_pipe #(
        .DATA_DEPTH(16), .RD_LATENCY(2), .MODE(RAM_NO_CHANGE)
    ) u_c (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct {
        logic        w;
        logic [3:0]  be;
        logic [9:0]  aa;
        logic [31:0] d;
        logic        r;
        logic [9:0]  ab;
        logic        v;
        logic        c;
        logic [31:0] q;
    } vec_t;

    function automatic vec_t mk(logic w, logic [3:0] be, logic [9:0] aa,
                                logic [31:0] d, logic r, logic [9:0] ab,
                                logic v, logic c, logic [31:0] q);
        vec_t t;
        t.w = w; t.be = be; t.aa = aa; t.d = d;
        t.r = r; t.ab = ab; t.v = v; t.c = c; t.q = q;
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic w, logic [3:0] be, logic [9:0] aa,
                         logic [31:0] d, logic r, logic [9:0] ab);
        wen = w; wbe = be; addra = aa; din = d; ren = r; addrb = ab;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] outs(int k);
        case (k)
            0:       return {ifa.dout_vld, ifa.rd_coll, ifa.dout};
            1:       return {ifb.dout_vld, ifb.rd_coll, ifb.dout};
            default: return {ifc.dout_vld, ifc.rd_coll, ifc.dout};
        endcase
    endfunction

    // Samples the driven request, then expects the result exactly lat cycles on.
    task automatic expect_rd(string nm, int k, int lat,
                             logic v, logic c, logic [31:0] q);
        logic [33:0] o;
        tick();
        idle();
        for (int i = 1; i < lat; i++) begin
            o = outs(k);
            chk({nm, "_early"}, {30'b0, o[33:32]}, 32'h0);
            tick();
        end
        o = outs(k);
        chk({nm, "_vld"}, {31'b0, o[33]}, {31'b0, v});
        chk({nm, "_coll"}, {31'b0, o[32]}, {31'b0, c});
        chk({nm, "_dout"}, o[31:0], q);
    endtask

    task automatic wait_ready();
        int n = 0;
        while ((ifa.init_busy || ifb.init_busy || ifc.init_busy) && n < 3000) begin
            tick();
            n++;
        end
        chk("init_done", {31'b0, ifa.init_busy | ifb.init_busy | ifc.init_busy}, 32'h0);
    endtask

    task automatic flush(int n);
        idle();
        repeat (n) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[14];
        logic [33:0] o;
        logic [31:0] bb[4];

        tbl[0]  = mk(1'b1, 4'hF, 10'd5,    32'hDEADBEEF, 1'b0, 10'd0,    1'b0, 1'b0, 32'h0);
        tbl[1]  = mk(1'b0, 4'h0, 10'd0,    32'h0,        1'b1, 10'd5,    1'b1, 1'b0, 32'hDEADBEEF);
        tbl[2]  = mk(1'b0, 4'h0, 10'd0,    32'h0,        1'b0, 10'd0,    1'b0, 1'b0, 32'hDEADBEEF);
        tbl[3]  = mk(1'b1, 4'hF, 10'd7,    32'h11223344, 1'b0, 10'd0,    1'b0, 1'b0, 32'hDEADBEEF);
        tbl[4]  = mk(1'b1, 4'h5, 10'd7,    32'hAABBCCDD, 1'b0, 10'd0,    1'b0, 1'b0, 32'hDEADBEEF);
        tbl[5]  = mk(1'b0, 4'h0, 10'd0,    32'h0,        1'b1, 10'd7,    1'b1, 1'b0, 32'h11BB33DD);
        tbl[6]  = mk(1'b1, 4'hF, 10'd3,    32'h12345678, 1'b1, 10'd3,    1'b1, 1'b1, 32'h0);
        tbl[7]  = mk(1'b0, 4'h0, 10'd0,    32'h0,        1'b1, 10'd3,    1'b1, 1'b0, 32'h12345678);
        tbl[8]  = mk(1'b1, 4'h0, 10'd3,    32'hFFFFFFFF, 1'b1, 10'd3,    1'b1, 1'b0, 32'h12345678);
        tbl[9]  = mk(1'b1, 4'h1, 10'd9,    32'h000000FF, 1'b1, 10'd8,    1'b1, 1'b0, 32'h0);
        tbl[10] = mk(1'b1, 4'hF, 10'd1023, 32'hCAFEF00D, 1'b1, 10'd1023, 1'b1, 1'b1, 32'h0);
        tbl[11] = mk(1'b0, 4'h0, 10'd0,    32'h0,        1'b1, 10'd1023, 1'b1, 1'b0, 32'hCAFEF00D);
        tbl[12] = mk(1'b0, 4'h0, 10'd0,    32'h0,        1'b1, 10'd9,    1'b1, 1'b0, 32'h000000FF);
        tbl[13] = mk(1'b0, 4'h0, 10'd0,    32'h0,        1'b0, 10'd0,    1'b0, 1'b0, 32'h000000FF);

        bb[0] = 32'hA0A0A0A0;
        bb[1] = 32'hA1A1A1A1;
        bb[2] = 32'hA2A2A2A2;
        bb[3] = 32'h12345678;

        rst = 1'b1;
        idle();
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            o = outs(k);
            chk($sformatf("rst_vld%0d", k), {31'b0, o[33]}, 32'h0);
            chk($sformatf("rst_coll%0d", k), {31'b0, o[32]}, 32'h0);
            chk($sformatf("rst_dout%0d", k), o[31:0], 32'h0);
        end
        rst = 1'b0;
        wait_ready();

        // Latency-1 READ_FIRST instance, one row per cycle.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].w, tbl[i].be, tbl[i].aa, tbl[i].d, tbl[i].r, tbl[i].ab);
            tick();
            chk($sformatf("tbl%0d_vld", i), {31'b0, ifa.dout_vld}, {31'b0, tbl[i].v});
            chk($sformatf("tbl%0d_coll", i), {31'b0, ifa.rd_coll}, {31'b0, tbl[i].c});
            chk($sformatf("tbl%0d_dout", i), ifa.dout, tbl[i].q);
        end
        flush(4);

        // Latency-3 WRITE_FIRST instance, depth 1000.
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
        expect_rd("b_rd5", 1, 3, 1'b1, 1'b0, 32'hDEADBEEF);
        tick();
        chk("b_hold_vld", {31'b0, ifb.dout_vld}, 32'h0);
        chk("b_hold_dout", ifb.dout, 32'hDEADBEEF);
        drive(1'b1, 4'hF, 10'd4, 32'h12345678, 1'b1, 10'd4);
        expect_rd("b_wf", 1, 3, 1'b1, 1'b1, 32'h12345678);
        drive(1'b1, 4'h3, 10'd5, 32'h11111111, 1'b1, 10'd5);
        expect_rd("b_merge", 1, 3, 1'b1, 1'b1, 32'hDEAD1111);
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd4);
        expect_rd("b_after", 1, 3, 1'b1, 1'b0, 32'h12345678);
        drive(1'b1, 4'hF, 10'd1010, 32'h55555555, 1'b0, 10'd0);
        tick();
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd1010);
        expect_rd("b_oor", 1, 3, 1'b1, 1'b0, 32'h0);
        flush(4);

        // Latency-2 NO_CHANGE instance, depth 16.
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd7);
        expect_rd("c_rd7", 2, 2, 1'b1, 1'b0, 32'h11BB33DD);
        drive(1'b1, 4'hF, 10'd6, 32'h12345678, 1'b1, 10'd6);
        expect_rd("c_nc", 2, 2, 1'b0, 1'b1, 32'h11BB33DD);
        tick();
        chk("c_nc_clear", {30'b0, ifc.dout_vld, ifc.rd_coll}, 32'h0);
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd6);
        expect_rd("c_after", 2, 2, 1'b1, 1'b0, 32'h12345678);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'hF, 10'(i), bb[i], 1'b0, 10'd0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'(i));
            else idle();
            tick();
            if (i >= 1 && i <= 4) begin
                chk($sformatf("c_b2b%0d_vld", i), {31'b0, ifc.dout_vld}, 32'h1);
                chk($sformatf("c_b2b%0d_dout", i), ifc.dout, bb[i-1]);
            end else begin
                chk($sformatf("c_b2b%0d_vld", i), {31'b0, ifc.dout_vld}, 32'h0);
            end
        end

        // Reset with reads still in flight.
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd0);
        tick();
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd1);
        tick();
        chk("b_inflight", {31'b0, ifb.dout_vld}, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 3; k++) begin
                o = outs(k);
                chk($sformatf("mid_rst%0d_vld%0d", n, k), {31'b0, o[33]}, 32'h0);
                chk($sformatf("mid_rst%0d_dout%0d", n, k), o[31:0], 32'h0);
            end
            tick();
        end

`ifdef RAM_INIT_CLEAR_EN
        begin
            int   cnt;
            logic sawv;
            wait_ready();
            for (int i = 0; i < 16; i++) begin
                drive(1'b1, 4'hF, 10'(i), 32'h100 + 32'(i), 1'b0, 10'd0);
                tick();
            end
            rst = 1'b1;
            drive(1'b1, 4'hF, 10'd2, 32'hFFFFFFFF, 1'b1, 10'd2);
            tick();
            rst = 1'b0;
            cnt = 0;
            sawv = 1'b0;
            while (ifc.init_busy && cnt < 64) begin
                cnt++;
                if (ifc.dout_vld) sawv = 1'b1;
                tick();
            end
            idle();
            chk("c_sweep_len", 32'(cnt), 32'd16);
            chk("c_sweep_novld", {31'b0, sawv}, 32'h0);
            tick();
            chk("c_post_vld", {31'b0, ifc.dout_vld}, 32'h0);
            for (int i = 0; i < 16; i++) begin
                drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'(i));
                expect_rd($sformatf("c_clr%0d", i), 2, 2, 1'b1, 1'b0, 32'h0);
            end

            drive(1'b1, 4'hF, 10'd15, 32'h77, 1'b0, 10'd0);
            tick();
            drive(1'b1, 4'hF, 10'd0, 32'h77, 1'b0, 10'd0);
            tick();
            idle();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            repeat (7) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            cnt = 0;
            while (ifc.init_busy && cnt < 64) begin
                cnt++;
                tick();
            end
            chk("c_restart_len", 32'(cnt), 32'd16);
            drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd15);
            expect_rd("c_restart15", 2, 2, 1'b1, 1'b0, 32'h0);
            drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd0);
            expect_rd("c_restart0", 2, 2, 1'b1, 1'b0, 32'h0);
        end
`else
        chk("busy_a", {31'b0, ifa.init_busy}, 32'h0);
        chk("busy_b", {31'b0, ifb.init_busy}, 32'h0);
        chk("busy_c", {31'b0, ifc.init_busy}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
